mux_2to1_stream: RTL and testbench

- Packet-aware 2-to-1 stream multiplexer; the gathering counterpart of the 1-to-2 demux.
- Merges two valid/ready input streams into one registered output stream.
- Holds its grant for a whole packet, delimited by last.
- Tags every output beat with its source index, so a downstream demux can route it back.

---
 rtl/mux_pkg.sv | 13 +
 rtl/mux_out_reg.sv | 63 ++++++
 rtl/mux_2to1_stream.sv | 116 +++++++++++
 tb/tb_mux_2to1_stream.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// Shared types for the packet-aware 2-to-1 stream multiplexer.
// The FSM encoding is fixed so that the debug state output has stable values.
package mux_pkg;

  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY0 = 2'd1,
    BUSY1 = 2'd2
  } state_e;

endpackage

// File: rtl/mux_out_reg.sv
// Single-stage registered output slot: loads an accepted beat, drains on out_ready.
// can_load tells the arbiter whether a beat may be taken this cycle.
module mux_out_reg
  import mux_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  input  logic              load_sel,
  input  logic              out_ready,
  output logic              can_load,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              out_sel
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              last_q, last_d;
  logic              sel_q, sel_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    last_d  = last_q;
    sel_d   = sel_q;
    // A load in the same cycle as a drain replaces the old beat, so valid stays high.
    if (load) begin
      valid_d = 1'b1;
      data_d  = load_data;
      last_d  = load_last;
      sel_d   = load_sel;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
      sel_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
      sel_q   <= sel_d;
    end
  end

  assign can_load  = !valid_q || out_ready;
  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_last  = last_q;
  assign out_sel   = sel_q;

endmodule

// File: rtl/mux_2to1_stream.sv
// Packet-locked 2-to-1 stream mux with source tagging. Tie-break is round-robin,
// or fixed priority to channel 0 when MUX_FIXED_PRIO_EN is defined.
//
// Handshake: a beat moves on any port when valid & ready are both high at a
// rising clk edge; a source holds valid and its beat stable until accepted,
// and ready never depends on that port's own valid.
module mux_2to1_stream
  import mux_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in0_valid,
  output logic              in0_ready,
  input  logic [DATA_W-1:0] in0_data,
  input  logic              in0_last,
  input  logic              in1_valid,
  output logic              in1_ready,
  input  logic [DATA_W-1:0] in1_data,
  input  logic              in1_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              out_sel,
  output state_e            dbg_state
);

  state_e state_q, state_d;
`ifndef MUX_FIXED_PRIO_EN
  logic last_grant_q, last_grant_d;
`endif

  logic              can_load;
  logic              acc0, acc1;
  logic              load;
  logic [DATA_W-1:0] load_data;
  logic              load_last;
  logic              load_sel;

  always_comb begin
    state_d   = state_q;
`ifndef MUX_FIXED_PRIO_EN
    last_grant_d = last_grant_q;
`endif
    in0_ready = 1'b0;
    in1_ready = 1'b0;
    case (state_q)
      // Arbitration only; no beat is taken here, which costs one bubble per packet.
      IDLE: begin
        if (in0_valid && in1_valid) begin
`ifdef MUX_FIXED_PRIO_EN
          state_d = BUSY0;
`else
          state_d      = last_grant_q ? BUSY0 : BUSY1;
          last_grant_d = !last_grant_q;
`endif
        end else if (in0_valid) begin
          state_d = BUSY0;
        end else if (in1_valid) begin
          state_d = BUSY1;
        end
      end
      BUSY0: begin
        in0_ready = can_load;
        if (in0_valid && can_load && in0_last) state_d = IDLE;
      end
      BUSY1: begin
        in1_ready = can_load;
        if (in1_valid && can_load && in1_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
`ifndef MUX_FIXED_PRIO_EN
      last_grant_q <= 1'b1;
`endif
    end else begin
      state_q      <= state_d;
`ifndef MUX_FIXED_PRIO_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

  assign acc0      = in0_valid && in0_ready;
  assign acc1      = in1_valid && in1_ready;
  assign load      = acc0 || acc1;
  assign load_sel  = acc1;
  assign load_data = acc1 ? in1_data : in0_data;
  assign load_last = acc1 ? in1_last : in0_last;
  assign dbg_state = state_q;

  mux_out_reg #(
    .DATA_W(DATA_W)
  ) u_out_reg (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_data(load_data),
    .load_last(load_last),
    .load_sel (load_sel),
    .out_ready(out_ready),
    .can_load (can_load),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_last (out_last),
    .out_sel  (out_sel)
  );

endmodule

// File: tb/tb_mux_2to1_stream.sv
// Bench for mux_2to1_stream: directed scenarios followed by random traffic, with
// a packet-level reference model and an expected-beat scoreboard.
module tb_mux_2to1_stream;
  import mux_pkg::*;

  localparam int DW = 8;
  localparam int W  = DW + 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in0_valid = 1'b0, in0_last = 1'b0, in1_valid = 1'b0, in1_last = 1'b0;
  logic [DW-1:0] in0_data = '0, in1_data = '0;
  logic          in0_ready, in1_ready;
  logic          out_valid, out_last, out_sel;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  state_e        dbg_state;

  mux_2to1_stream #(.DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .in0_valid(in0_valid), .in0_ready(in0_ready), .in0_data(in0_data), .in0_last(in0_last),
    .in1_valid(in1_valid), .in1_ready(in1_ready), .in1_data(in1_data), .in1_last(in1_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .out_sel(out_sel), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  int vecs = 0;
  int errs = 0;
  int cyc  = 0;

  // reference model: packet owner (-1 none), tie memory, output slot
  int            m_owner = -1;
  logic          m_lg = 1'b1;
  logic          m_ov = 1'b0, m_ol = 1'b0, m_os = 1'b0;
  logic [DW-1:0] m_od = '0;
  logic          m_acc0, m_acc1;

  logic [W-1:0]  exp_q[$];
  logic [W-1:0]  out_log[$];
  int            out_cyc[$];

  // per-channel sources
  logic [DW:0]   src_q0[$], src_q1[$];
  logic          g_val[2];
  logic [DW-1:0] g_data[2];
  logic          g_last[2];
  logic          hold[2];
  int            acc_cnt[2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: compare DUT against model at the falling edge, then advance the model.
  task automatic tick();
    logic         e_r0, e_r1, acc, was_idle, l;
    logic [DW-1:0] d;
    logic [W-1:0] got, want;
    #4;
    e_r0 = (m_owner == 0) && (!m_ov || out_ready);
    e_r1 = (m_owner == 1) && (!m_ov || out_ready);
    chk("in0_ready", 32'(in0_ready), 32'(e_r0));
    chk("in1_ready", 32'(in1_ready), 32'(e_r1));
    chk("out_valid", 32'(out_valid), 32'(m_ov));
    chk("out_data",  32'(out_data),  32'(m_od));
    chk("out_last",  32'(out_last),  32'(m_ol));
    chk("out_sel",   32'(out_sel),   32'(m_os));
    chk("state",     32'(dbg_state), 32'(m_owner + 1));
    if (out_valid && out_ready) begin
      got = {out_sel, out_last, out_data};
      out_log.push_back(got);
      out_cyc.push_back(cyc);
      want = (exp_q.size() > 0) ? exp_q.pop_front() : {W{1'bx}};
      chk("scoreboard", 32'(got), 32'(want));
    end
    m_acc0 = 1'b0;
    m_acc1 = 1'b0;
    if (rst) begin
      m_owner = -1; m_lg = 1'b1; m_ov = 1'b0; m_od = '0; m_ol = 1'b0; m_os = 1'b0;
      exp_q.delete();
    end else begin
      was_idle = (m_owner < 0);
      acc = (m_owner == 0) ? (in0_valid && e_r0) : (m_owner == 1) ? (in1_valid && e_r1) : 1'b0;
      if (acc) begin
        d = (m_owner == 1) ? in1_data : in0_data;
        l = (m_owner == 1) ? in1_last : in0_last;
        exp_q.push_back({m_owner == 1, l, d});
        m_od = d; m_ol = l; m_os = (m_owner == 1); m_ov = 1'b1;
        if (m_owner == 1) m_acc1 = 1'b1; else m_acc0 = 1'b1;
        if (l) m_owner = -1;
      end else if (m_ov && out_ready) begin
        m_ov = 1'b0;
      end
      if (was_idle) begin
        if (in0_valid && in1_valid) begin
`ifdef MUX_FIXED_PRIO_EN
          m_owner = 0;
`else
          m_owner = (m_lg == 1'b1) ? 0 : 1;
          m_lg    = (m_owner == 1);
`endif
        end else if (in0_valid) m_owner = 0;
        else if (in1_valid) m_owner = 1;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // driver: present queued beats, hold each until the model says it was accepted
  task automatic run_cycle();
    logic [DW:0] b;
    if (!g_val[0] && !hold[0] && src_q0.size() > 0) begin
      b = src_q0.pop_front(); g_val[0] = 1'b1; g_last[0] = b[DW]; g_data[0] = b[DW-1:0];
    end
    if (!g_val[1] && !hold[1] && src_q1.size() > 0) begin
      b = src_q1.pop_front(); g_val[1] = 1'b1; g_last[1] = b[DW]; g_data[1] = b[DW-1:0];
    end
    in0_valid = g_val[0]; in0_data = g_data[0]; in0_last = g_last[0];
    in1_valid = g_val[1]; in1_data = g_data[1]; in1_last = g_last[1];
    tick();
    if (m_acc0) begin g_val[0] = 1'b0; acc_cnt[0]++; end
    if (m_acc1) begin g_val[1] = 1'b0; acc_cnt[1]++; end
  endtask

  task automatic run_until_idle(input int max);
    int n;
    n = 0;
    while ((src_q0.size() > 0 || src_q1.size() > 0 || g_val[0] || g_val[1] || m_ov || m_owner >= 0)
           && n < max) begin
      run_cycle();
      n++;
    end
    chk("drain_budget", 32'(n < max), 32'd1);
  endtask

  task automatic clear_log();
    out_log.delete();
    out_cyc.delete();
  endtask

  initial begin
    int t0, base;
    logic [7:0] exp_d[3];
    exp_d = '{8'h11, 8'h22, 8'h33};
    for (int k = 0; k < 2; k++) begin
      g_val[k] = 1'b0; g_data[k] = '0; g_last[k] = 1'b0; hold[k] = 1'b0; acc_cnt[k] = 0;
    end
    @(posedge clk);
    #1;

    // reset held two cycles with both inputs valid; channel 0 wins the first tie
    src_q0.push_back({1'b1, 8'hA1});
    src_q1.push_back({1'b1, 8'hB1});
    run_cycle();
    run_cycle();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in0_ready", 32'(in0_ready), 32'd0);
    chk("rst_in1_ready", 32'(in1_ready), 32'd0);
    rst = 1'b0;
    out_ready = 1'b1;
    clear_log();
    run_until_idle(40);
    chk("first_grant_cnt", 32'(out_log.size()), 32'd2);
    if (out_log.size() == 2) begin
      chk("first_grant0", 32'(out_log[0]), 32'({1'b0, 1'b1, 8'hA1}));
      chk("first_grant1", 32'(out_log[1]), 32'({1'b1, 1'b1, 8'hB1}));
    end

    // single channel 3-beat packet, no backpressure
    clear_log();
    t0 = cyc;
    for (int i = 0; i < 3; i++) src_q0.push_back({i == 2, exp_d[i]});
    run_until_idle(40);
    chk("single_cnt", 32'(out_log.size()), 32'd3);
    for (int i = 0; i < out_log.size() && i < 3; i++) begin
      chk("single_beat", 32'(out_log[i]), 32'({1'b0, i == 2, exp_d[i]}));
      chk("single_cycle", 32'(out_cyc[i]), 32'(t0 + 2 + i));
    end

    // contended single-beat packets
    clear_log();
    for (int i = 0; i < 4; i++) begin
      src_q0.push_back({1'b1, 8'(8'hA0 + i)});
      src_q1.push_back({1'b1, 8'(8'hB0 + i)});
    end
    run_until_idle(80);
    chk("tie_cnt", 32'(out_log.size()), 32'd8);
    for (int i = 1; i < out_log.size(); i++) begin
`ifdef MUX_FIXED_PRIO_EN
      chk("fixed_sel", 32'(out_log[i][W-1]), 32'(i >= 4));
`else
      chk("rr_alternate", 32'(out_log[i][W-1]), 32'(!out_log[i-1][W-1]));
`endif
      chk("tie_bubble", 32'(out_cyc[i] - out_cyc[i-1]), 32'd2);
    end

    // backpressure mid-packet
    clear_log();
    for (int i = 0; i < 4; i++) src_q0.push_back({i == 3, 8'(8'hC0 + i)});
    for (int i = 0; i < 3; i++) run_cycle();
    for (int i = 0; i < 3; i++) begin
      out_ready = 1'b0;
      #1;
      chk("bp_hold_data", 32'(out_data), 32'h0C1);
      chk("bp_in0_ready", 32'(in0_ready), 32'd0);
      run_cycle();
    end
    out_ready = 1'b1;
    run_until_idle(40);
    chk("bp_cnt", 32'(out_log.size()), 32'd4);
    for (int i = 0; i < out_log.size() && i < 4; i++)
      chk("bp_beat", 32'(out_log[i]), 32'({1'b0, i == 3, 8'(8'hC0 + i)}));

    // packet lock: channel 1 keeps the grant across its own valid gap
    clear_log();
    base = acc_cnt[1];
    for (int i = 0; i < 4; i++) src_q1.push_back({i == 3, 8'(8'hD0 + i)});
    for (int n = 0; n < 10 && acc_cnt[1] < base + 2; n++) run_cycle();
    chk("lock_two_beats", 32'(acc_cnt[1] - base), 32'd2);
    hold[1] = 1'b1;
    src_q0.push_back({1'b1, 8'hE0});
    for (int i = 0; i < 2; i++) begin
      run_cycle();
      chk("lock_in0_ready", 32'(in0_ready), 32'd0);
    end
    hold[1] = 1'b0;
    run_until_idle(40);
    chk("lock_cnt", 32'(out_log.size()), 32'd5);
    for (int i = 0; i < out_log.size() && i < 5; i++)
      chk("lock_beat", 32'(out_log[i]),
          (i < 4) ? 32'({1'b1, i == 3, 8'(8'hD0 + i)}) : 32'({1'b0, 1'b1, 8'hE0}));

    // reset in the middle of a packet
    base = acc_cnt[0];
    for (int i = 0; i < 4; i++) src_q0.push_back({i == 3, 8'(8'hF0 + i)});
    for (int n = 0; n < 10 && acc_cnt[0] < base + 2; n++) run_cycle();
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    run_cycle();
    rst = 1'b0;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_state", 32'(dbg_state), 32'(IDLE));
    src_q0.delete();
    g_val[0] = 1'b0;
    clear_log();
    src_q1.push_back({1'b0, 8'h5A});
    src_q1.push_back({1'b1, 8'h5B});
    run_until_idle(40);
    chk("post_rst_cnt", 32'(out_log.size()), 32'd2);
    if (out_log.size() == 2) begin
      chk("post_rst_beat0", 32'(out_log[0]), 32'({1'b1, 1'b0, 8'h5A}));
      chk("post_rst_beat1", 32'(out_log[1]), 32'({1'b1, 1'b1, 8'h5B}));
    end

    // random traffic
    for (int n = 0; n < 1500; n++) begin
      if (src_q0.size() < 3 && $urandom_range(0, 2) == 0)
        src_q0.push_back({$urandom_range(0, 2) == 0, 8'($urandom)});
      if (src_q1.size() < 3 && $urandom_range(0, 2) == 0)
        src_q1.push_back({$urandom_range(0, 2) == 0, 8'($urandom)});
      hold[0]   = ($urandom_range(0, 4) == 0);
      hold[1]   = ($urandom_range(0, 4) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      rst       = ($urandom_range(0, 299) == 0);
      run_cycle();
    end
    rst = 1'b0;
    hold[0] = 1'b0;
    hold[1] = 1'b0;
    out_ready = 1'b1;
    src_q0.push_back({1'b1, 8'h01});
    src_q1.push_back({1'b1, 8'h02});
    run_until_idle(200);
    chk("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
